// File: rtl/bp_me_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : bp_me_pkg                                                      |
// | Purpose : Shared types for the BedRock stream protocol checker: error    |
// |           codes, per-channel FSM states and the expected-beat helper.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package bp_me_pkg;

    typedef enum logic [2:0] {
        e_err_none    = 3'd0,
        e_err_size    = 3'd1,
        e_err_last    = 3'd2,
        e_err_header  = 3'd3,
        e_err_hold    = 3'd4,
        e_err_timeout = 3'd5
    } bp_stream_verif_err_e;

    typedef enum logic [0:0] {
        e_idle   = 1'b0,
        e_stream = 1'b1
    } bp_stream_verif_state_e;

    // Beats a message occupies on the stream. Header-only messages and
    // payloads narrower than one beat take a single beat; oversized
    // messages are clamped so the beat counter never wraps.
    function automatic int bp_stream_beats(input logic [2:0] size,
                                           input logic       has_data,
                                           input int         data_width,
                                           input int         max_beats);
        int raw;
        raw = int'((32'd8 << size) / 32'(data_width));
        if (!has_data || (raw == 0)) return 1;
        if (raw > max_beats) return max_beats;
        return raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_nonsynth_stream_channel_verif.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_nonsynth_stream_channel_verif                               |
// | Purpose : Protocol checker for one ready&valid header+data stream.       |
// |           Tracks message framing, header stability, hold-while-stalled   |
// |           and stall timeout; records the first error and counts          |
// |           completed messages. Observes only, never drives the stream.    |
// | Ports   : clk_i, reset_i        clock, sync active-high reset            |
// |           header_i/data_i/size_i/has_data_i/v_i/ready_and_i/last_i       |
// |                                 monitored stream signals                 |
// |           err_o                 sticky error flag                        |
// |           err_code_o            first error code                         |
// |           msg_count_o           completed messages (wraps at 2^32)       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bp_nonsynth_stream_channel_verif
    import bp_me_pkg::*;
#(
    parameter int channel_p      = 0,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int block_width_p  = 512,
    parameter int timeout_p      = 1024,
    parameter bit hold_check_p   = 1'b1,
    parameter bit fatal_p        = 1'b0,
    parameter bit report_p       = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [header_width_p-1:0] header_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [2:0]                size_i,
    input  logic                      has_data_i,
    input  logic                      v_i,
    input  logic                      ready_and_i,
    input  logic                      last_i,
    output logic                      err_o,
    output bp_stream_verif_err_e      err_code_o,
    output logic [31:0]               msg_count_o
);

    localparam int c_max_beats = block_width_p / data_width_p;
    localparam int c_beat_w    = $clog2(c_max_beats) + 1;

    bp_stream_verif_state_e    state_q, state_d;
    logic [header_width_p-1:0] header_q, header_d;
    logic [c_beat_w-1:0]       beats_q, beats_d;
    logic [c_beat_w-1:0]       beat_q, beat_d;
    logic [31:0]               stall_cnt_q, stall_cnt_d;
    logic                      err_q, err_d;
    bp_stream_verif_err_e      err_code_q, err_code_d;
    logic [31:0]               msg_count_q, msg_count_d;

    // Previous-cycle snapshot used by the hold check
    logic                      prev_stall_q;
    logic [header_width_p-1:0] prev_header_q;
    logic [data_width_p-1:0]   prev_data_q;
    logic [2:0]                prev_size_q;
    logic                      prev_has_data_q;
    logic                      prev_last_q;

    logic                      w_hs;
    logic                      w_stall;
    logic [c_beat_w-1:0]       w_beats;
    logic                      w_size_bad;
    logic                      w_final;
    logic                      w_err_size, w_err_last, w_err_header, w_err_hold, w_err_timeout;
    logic                      w_any_err;
    bp_stream_verif_err_e      w_code;

    assign w_hs       = v_i & ready_and_i;
    assign w_stall    = v_i & ~ready_and_i;
    assign w_beats    = c_beat_w'(bp_stream_beats(size_i, has_data_i, data_width_p, c_max_beats));
    assign w_size_bad = (32'd8 << size_i) > 32'(block_width_p);
    // beat_q counts beats already accepted, so the final beat arrives when
    // exactly N-1 have gone before it
    assign w_final    = (beat_q == (beats_q - c_beat_w'(1)));

    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        beats_d       = beats_q;
        beat_d        = beat_q;
        msg_count_d   = msg_count_q;
        stall_cnt_d   = stall_cnt_q;
        w_err_size    = 1'b0;
        w_err_last    = 1'b0;
        w_err_header  = 1'b0;
        w_err_hold    = 1'b0;
        w_err_timeout = 1'b0;

        case (state_q)
            e_idle: begin
                if (w_hs) begin
                    header_d   = header_i;
                    beats_d    = w_beats;
                    beat_d     = c_beat_w'(1);
                    w_err_size = w_size_bad;
                    if (w_beats == c_beat_w'(1)) begin
                        w_err_last  = ~last_i;
                        msg_count_d = msg_count_q + 32'd1;
                    end else begin
                        w_err_last = last_i;
                        state_d    = e_stream;
                    end
                end
            end
            e_stream: begin
                if (w_hs) begin
                    w_err_header = (header_i != header_q);
                    beat_d       = beat_q + c_beat_w'(1);
                    w_err_last   = (last_i != w_final);
                    if (w_final) begin
                        state_d     = e_idle;
                        msg_count_d = msg_count_q + 32'd1;
                    end
                end
            end
            default: state_d = e_idle;
        endcase

        if (hold_check_p && prev_stall_q) begin
            w_err_hold = ~v_i
                       | (header_i   != prev_header_q)
                       | (data_i     != prev_data_q)
                       | (size_i     != prev_size_q)
                       | (has_data_i != prev_has_data_q)
                       | (last_i     != prev_last_q);
        end

        // Counter saturates at the limit so each stall episode fires once
        if (!w_stall) begin
            stall_cnt_d = 32'd0;
        end else if ((timeout_p != 0) && (stall_cnt_q != 32'(timeout_p))) begin
            stall_cnt_d   = stall_cnt_q + 32'd1;
            w_err_timeout = ((stall_cnt_q + 32'd1) == 32'(timeout_p));
        end

        if (w_err_size)         w_code = e_err_size;
        else if (w_err_last)    w_code = e_err_last;
        else if (w_err_header)  w_code = e_err_header;
        else if (w_err_hold)    w_code = e_err_hold;
        else if (w_err_timeout) w_code = e_err_timeout;
        else                    w_code = e_err_none;

        w_any_err  = w_err_size | w_err_last | w_err_header | w_err_hold | w_err_timeout;
        err_d      = err_q | w_any_err;
        err_code_d = (!err_q && w_any_err) ? w_code : err_code_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= e_idle;
            header_q        <= '0;
            beats_q         <= '0;
            beat_q          <= '0;
            stall_cnt_q     <= '0;
            err_q           <= 1'b0;
            err_code_q      <= e_err_none;
            msg_count_q     <= '0;
            prev_stall_q    <= 1'b0;
            prev_header_q   <= '0;
            prev_data_q     <= '0;
            prev_size_q     <= '0;
            prev_has_data_q <= 1'b0;
            prev_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            header_q        <= header_d;
            beats_q         <= beats_d;
            beat_q          <= beat_d;
            stall_cnt_q     <= stall_cnt_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
            msg_count_q     <= msg_count_d;
            prev_stall_q    <= w_stall;
            prev_header_q   <= header_i;
            prev_data_q     <= data_i;
            prev_size_q     <= size_i;
            prev_has_data_q <= has_data_i;
            prev_last_q     <= last_i;
        end
    end

    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign msg_count_o = msg_count_q;

    // Runtime messages; every error is reported, not only the first
    if (report_p) begin : g_report
        logic [63:0] cycle_q;
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cycle_q <= '0;
            end else begin
                cycle_q <= cycle_q + 64'd1;
                if (w_any_err) begin
                    if (fatal_p)
                        $fatal(1, "stream_verif ch%0d: error code %0d at cycle %0d",
                               channel_p, w_code, cycle_q);
                    else
                        $error("stream_verif ch%0d: error code %0d at cycle %0d",
                               channel_p, w_code, cycle_q);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_nonsynth_stream_verif.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_nonsynth_stream_verif                                       |
// | Purpose : Runtime protocol checker for num_channels_p independent        |
// |           BedRock ready&valid header+data streams. Sits beside the DUT   |
// |           and only observes.                                             |
// | Ports   : clk_i, reset_i      clock, sync active-high reset              |
// |           header_i/data_i/size_i/has_data_i/v_i/ready_and_i/last_i       |
// |                               flattened per-channel stream signals       |
// |           err_o               sticky per-channel error                   |
// |           err_code_o          first error code per channel (3b each)     |
// |           msg_count_o         completed messages per channel (32b each)  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bp_nonsynth_stream_verif
    import bp_me_pkg::*;
#(
    parameter int num_channels_p = 2,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int block_width_p  = 512,
    parameter int timeout_p      = 1024,
    parameter bit hold_check_p   = 1'b1,
    parameter bit fatal_p        = 1'b0,
    // 0 silences the per-error runtime messages; flags and codes still record
    parameter bit report_p       = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_channels_p*header_width_p-1:0] header_i,
    input  logic [num_channels_p*data_width_p-1:0]   data_i,
    input  logic [num_channels_p*3-1:0]              size_i,
    input  logic [num_channels_p-1:0]                has_data_i,
    input  logic [num_channels_p-1:0]                v_i,
    input  logic [num_channels_p-1:0]                ready_and_i,
    input  logic [num_channels_p-1:0]                last_i,
    output logic [num_channels_p-1:0]                err_o,
    output logic [num_channels_p*3-1:0]              err_code_o,
    output logic [num_channels_p*32-1:0]             msg_count_o
);

    if ((data_width_p & (data_width_p - 1)) != 0) begin : g_chk_data_width
        $error("bp_nonsynth_stream_verif: data_width_p (%0d) is not a power of two", data_width_p);
    end
    if ((block_width_p % data_width_p) != 0) begin : g_chk_block_width
        $error("bp_nonsynth_stream_verif: block_width_p (%0d) not a multiple of data_width_p (%0d)",
               block_width_p, data_width_p);
    end
    if (num_channels_p == 0) begin : g_chk_channels
        $error("bp_nonsynth_stream_verif: num_channels_p must be non-zero");
    end

    for (genvar i = 0; i < num_channels_p; i++) begin : g_channel
        bp_stream_verif_err_e w_code;

        bp_nonsynth_stream_channel_verif #(
            .channel_p      (i),
            .header_width_p (header_width_p),
            .data_width_p   (data_width_p),
            .block_width_p  (block_width_p),
            .timeout_p      (timeout_p),
            .hold_check_p   (hold_check_p),
            .fatal_p        (fatal_p),
            .report_p       (report_p)
        ) u_chan (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .header_i    (header_i[i*header_width_p +: header_width_p]),
            .data_i      (data_i[i*data_width_p +: data_width_p]),
            .size_i      (size_i[i*3 +: 3]),
            .has_data_i  (has_data_i[i]),
            .v_i         (v_i[i]),
            .ready_and_i (ready_and_i[i]),
            .last_i      (last_i[i]),
            .err_o       (err_o[i]),
            .err_code_o  (w_code),
            .msg_count_o (msg_count_o[i*32 +: 32])
        );

        assign err_code_o[i*3 +: 3] = w_code;
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_nonsynth_stream_verif.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bp_nonsynth_stream_verif                                    |
// | Purpose : Directed self-checking bench for the stream protocol checker   |
// |           (two 64-bit channels, 512-bit blocks, 16-cycle timeout).       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_bp_nonsynth_stream_verif;
    import bp_me_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [127:0] header_i;
    logic [127:0] data_i;
    logic [5:0]   size_i;
    logic [1:0]   has_data_i;
    logic [1:0]   v_i;
    logic [1:0]   ready_and_i;
    logic [1:0]   last_i;
    logic [1:0]   err_o;
    logic [5:0]   err_code_o;
    logic [63:0]  msg_count_o;

    int tests_run = 0;
    int tests_failed = 0;

    bp_nonsynth_stream_verif #(
        .num_channels_p (2),
        .header_width_p (64),
        .data_width_p   (64),
        .block_width_p  (512),
        .timeout_p      (16),
        .hold_check_p   (1'b1),
        .fatal_p        (1'b0),
        .report_p       (1'b0)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .header_i    (header_i),
        .data_i      (data_i),
        .size_i      (size_i),
        .has_data_i  (has_data_i),
        .v_i         (v_i),
        .ready_and_i (ready_and_i),
        .last_i      (last_i),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .msg_count_o (msg_count_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [63:0] hdr, input logic [63:0] dat,
                          input logic [2:0] sz, input logic hd, input logic v,
                          input logic r, input logic l);
        header_i[ch*64 +: 64] = hdr;
        data_i[ch*64 +: 64]   = dat;
        size_i[ch*3 +: 3]     = sz;
        has_data_i[ch]        = hd;
        v_i[ch]               = v;
        ready_and_i[ch]       = r;
        last_i[ch]            = l;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        header_i    = '0;
        data_i      = '0;
        size_i      = '0;
        has_data_i  = '0;
        v_i         = '0;
        ready_and_i = '0;
        last_i      = '0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (err_o !== 2'b00) begin
            tests_failed++; $display("FAIL reset_err: got %b expected 00", err_o);
        end
        tests_run++;
        if (err_code_o !== 6'd0) begin
            tests_failed++; $display("FAIL reset_code: got %h expected 00", err_code_o);
        end
        tests_run++;
        if (msg_count_o !== 64'd0) begin
            tests_failed++; $display("FAIL reset_count: got %h expected 0", msg_count_o);
        end
    endtask

    // 64B message, 8 beats of 64 bits, last on beat 7
    task automatic test_full_msg();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_ch(0, 64'hA5A5_0000_0000_0001, 64'(k), 3'd6, 1'b1, 1'b1, 1'b1, k == 7);
            tick();
            if (k == 6) begin
                tests_run++;
                if (msg_count_o[31:0] !== 32'd0) begin
                    tests_failed++; $display("FAIL full_count_early: got %0d expected 0", msg_count_o[31:0]);
                end
            end
        end
        set_ch(0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (msg_count_o[31:0] !== 32'd1) begin
            tests_failed++; $display("FAIL full_count: got %0d expected 1", msg_count_o[31:0]);
        end
        tests_run++;
        if (err_o !== 2'b00) begin
            tests_failed++; $display("FAIL full_err: got %b expected 00", err_o);
        end
        tests_run++;
        if (msg_count_o[63:32] !== 32'd0) begin
            tests_failed++; $display("FAIL full_other_ch: got %0d expected 0", msg_count_o[63:32]);
        end
    endtask

    // Same 8-beat message with last wrongly asserted on beat 5
    task automatic test_last_err();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_ch(0, 64'h1234, 64'(k), 3'd6, 1'b1, 1'b1, 1'b1, k == 5);
            tick();
            if (k == 4) begin
                tests_run++;
                if (err_o[0] !== 1'b0) begin
                    tests_failed++; $display("FAIL last_err_early: got %b expected 0", err_o[0]);
                end
            end
            if (k == 5) begin
                tests_run++;
                if (err_o[0] !== 1'b1 || err_code_o[2:0] !== e_err_last) begin
                    tests_failed++;
                    $display("FAIL last_err: got err=%b code=%0d expected err=1 code=%0d",
                             err_o[0], err_code_o[2:0], e_err_last);
                end
            end
        end
        tests_run++;
        if (msg_count_o[31:0] !== 32'd1) begin
            tests_failed++; $display("FAIL last_err_count: got %0d expected 1", msg_count_o[31:0]);
        end
        // Back in idle: a header-only message completes immediately
        set_ch(0, 64'h55, 64'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_ch(0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (msg_count_o[31:0] !== 32'd2 || err_code_o[2:0] !== e_err_last) begin
            tests_failed++;
            $display("FAIL last_err_recover: got count=%0d code=%0d expected count=2 code=%0d",
                     msg_count_o[31:0], err_code_o[2:0], e_err_last);
        end
    endtask

    // Payload changes while stalled
    task automatic test_hold();
        do_reset();
        set_ch(0, 64'h77, 64'hDEAD, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        tests_run++;
        if (err_o[0] !== 1'b0) begin
            tests_failed++; $display("FAIL hold_early: got %b expected 0", err_o[0]);
        end
        set_ch(0, 64'h77, 64'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        tests_run++;
        if (err_o[0] !== 1'b1 || err_code_o[2:0] !== e_err_hold) begin
            tests_failed++;
            $display("FAIL hold_err: got err=%b code=%0d expected err=1 code=%0d",
                     err_o[0], err_code_o[2:0], e_err_hold);
        end
        set_ch(0, 64'h77, 64'hBEEF, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_ch(0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (msg_count_o[31:0] !== 32'd1) begin
            tests_failed++; $display("FAIL hold_count: got %0d expected 1", msg_count_o[31:0]);
        end
    endtask

    // Legal 20-cycle stall: timeout fires at the 16th stall cycle
    task automatic test_timeout();
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            set_ch(0, 64'h99, 64'h42, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
            if (c == 15) begin
                tests_run++;
                if (err_o[0] !== 1'b0) begin
                    tests_failed++; $display("FAIL timeout_early: got %b expected 0", err_o[0]);
                end
            end
            if (c == 16) begin
                tests_run++;
                if (err_o[0] !== 1'b1 || err_code_o[2:0] !== e_err_timeout) begin
                    tests_failed++;
                    $display("FAIL timeout_err: got err=%b code=%0d expected err=1 code=%0d",
                             err_o[0], err_code_o[2:0], e_err_timeout);
                end
            end
        end
        set_ch(0, 64'h99, 64'h42, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_ch(0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (msg_count_o[31:0] !== 32'd1 || err_code_o[2:0] !== e_err_timeout) begin
            tests_failed++;
            $display("FAIL timeout_complete: got count=%0d code=%0d expected count=1 code=%0d",
                     msg_count_o[31:0], err_code_o[2:0], e_err_timeout);
        end
    endtask

    // ch0: header changes on beat 3 of 4; ch1: oversize message same cycle
    task automatic test_dual_errors();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_ch(0, (k == 3) ? 64'hC0DE_0001 : 64'hC0DE_0000, 64'(k), 3'd5, 1'b1, 1'b1, 1'b1, k == 3);
            if (k == 3) set_ch(1, 64'hF00D, 64'h0, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1);
            else        set_ch(1, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (k == 2) begin
                tests_run++;
                if (err_o !== 2'b00) begin
                    tests_failed++; $display("FAIL dual_early: got %b expected 00", err_o);
                end
            end
        end
        set_ch(0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_ch(1, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (err_o !== 2'b11) begin
            tests_failed++; $display("FAIL dual_err: got %b expected 11", err_o);
        end
        tests_run++;
        if (err_code_o[2:0] !== e_err_header) begin
            tests_failed++; $display("FAIL dual_code0: got %0d expected %0d", err_code_o[2:0], e_err_header);
        end
        tests_run++;
        if (err_code_o[5:3] !== e_err_size) begin
            tests_failed++; $display("FAIL dual_code1: got %0d expected %0d", err_code_o[5:3], e_err_size);
        end
        tests_run++;
        if (msg_count_o !== {32'd1, 32'd1}) begin
            tests_failed++; $display("FAIL dual_count: got %h expected 0000000100000001", msg_count_o);
        end
    endtask

    // Reset during beat 2 of an 8-beat message, then a fresh 1-beat message
    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_ch(0, 64'hAB, 64'(k), 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        reset_i = 1'b1;
        set_ch(0, 64'hAB, 64'd2, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        reset_i = 1'b0;
        set_ch(0, 64'hCD, 64'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_ch(0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (err_o[0] !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_err: got %b expected 0", err_o[0]);
        end
        tests_run++;
        if (msg_count_o[31:0] !== 32'd1) begin
            tests_failed++; $display("FAIL reset_mid_count: got %0d expected 1", msg_count_o[31:0]);
        end
    endtask

    // ch1: two 2-beat messages and a sub-beat payload message, no gaps
    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_ch(1, 64'(100 + k / 2), 64'(k), 3'd4, 1'b1, 1'b1, 1'b1, (k % 2) == 1);
            tick();
        end
        set_ch(1, 64'd300, 64'h1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        set_ch(1, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (msg_count_o[63:32] !== 32'd3) begin
            tests_failed++; $display("FAIL b2b_count: got %0d expected 3", msg_count_o[63:32]);
        end
        tests_run++;
        if (err_o !== 2'b00) begin
            tests_failed++; $display("FAIL b2b_err: got %b expected 00", err_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_msg();
        test_last_err();
        test_hold();
        test_timeout();
        test_dual_errors();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bp_nonsynth_stream_verif.md
Name: bp_nonsynth_stream_verif

Overview:
- Non-synthesisable, runtime protocol checker for N parallel BedRock ready&valid header+data streams, e.g. CCE-mem command/response and LCE req/cmd/resp.
- Extends elaboration-time parameter checking into cycle-level checks:
  - valid/payload hold while stalled;
  - header stability across beats;
  - beat count vs. message size, with correct last flag;
  - stall timeout.
- Instantiated in the testbench beside the DUT, one port set per monitored channel.
- Never drives the DUT.

Parameters:
- num_channels_p, 2, number of independently monitored streams.
- header_width_p, 64, flattened header width per channel.
- data_width_p, 64, stream data beat width in bits; power of two, >= 64.
- block_width_p, 512, maximum message payload in bits; multiple of data_width_p.
- timeout_p, 1024, max consecutive cycles valid may stay high without handshake; 0 disables the check.
- hold_check_p, 1, 1 = valid and payload must hold while valid & ~ready; 0 = skip the hold check.
- fatal_p, 0, 1 = $fatal on first error; 0 = $error and continue.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- header_i  in  num_channels_p*header_width_p  per-channel header.
- data_i  in  num_channels_p*data_width_p  per-channel data beat.
- size_i  in  num_channels_p*3  per-channel msg size, bytes = 1<<size.
- has_data_i  in  num_channels_p  per-channel: message carries payload.
- v_i  in  num_channels_p  per-channel valid.
- ready_and_i  in  num_channels_p  per-channel ready.
- last_i  in  num_channels_p  per-channel last-beat flag.
- err_o  out  num_channels_p  sticky per-channel error.
- err_code_o  out  num_channels_p*3  first error code per channel, bp_stream_verif_err_e.
- msg_count_o  out  num_channels_p*32  completed messages per channel; wraps at 2^32.

Behaviour:
- Reset (sync, active-high): every channel goes to e_idle; beat counter, stall counter, err_o and msg_count_o = 0; err_code_o = e_err_none. A message in flight when reset asserts is discarded, with no error reported.
- Handshake: hs = v_i & ready_and_i for the channel, sampled at posedge.
- Expected beats: N = has_data ? max(1, (8<<size)/data_width_p) : 1. Width: clog2(block_width_p/data_width_p)+1 bits.
- Error if 8<<size > block_width_p: e_err_size, checked on the first beat.
- Per-channel FSM, states e_idle and e_stream:
  - e_idle:
    - On hs, latch header and N; beat = 1.
    - If N == 1, last_i must be 1, else e_err_last; complete the message and stay in e_idle.
    - Else, last_i must be 0, else e_err_last; go to e_stream.
  - e_stream:
    - On hs, header_i must equal the latched header, else e_err_header.
    - Beat increments.
    - last_i must be 1 exactly when beat == N-1, else e_err_last.
    - On the last beat, complete the message and return to e_idle.
- Hold check (hold_check_p=1): if v_i & ~ready_and_i at cycle t, then at t+1 the following must be unchanged, else e_err_hold:
  - v_i must be 1;
  - header_i, data_i, size_i, has_data_i, last_i must be unchanged.
- Timeout: stall counter increments each cycle with v_i & ~ready_and_i and clears on hs or ~v_i. When it reaches timeout_p, raise e_err_timeout once per stall episode.
- Error reporting:
  - Errors are registered and visible on err_o the cycle after the offending edge.
  - err_code_o holds the first error only; later errors are still printed via $error with channel, code and cycle count.
  - An error does not alter FSM progress; the checker keeps tracking.
- msg_count_o increments on completion, the cycle after the final hs.
- Channels are fully independent; simultaneous errors on different channels are all recorded.
- Elaboration checks with $error: data_width_p not a power of two; block_width_p % data_width_p != 0; num_channels_p == 0.

Decomposition:
- bp_me_pkg holds:
  - bp_stream_verif_err_e: e_err_none=0, e_err_size, e_err_last, e_err_header, e_err_hold, e_err_timeout;
  - bp_stream_verif_state_e: e_idle, e_stream.
- Sub-module bp_nonsynth_stream_channel_verif: single-channel FSM, counters and checks. The top instantiates it num_channels_p times in a generate loop and slices the flattened ports.

Test Plan:
- data_width 64, size 6 (64B), has_data=1, 8 beats, last on beat 7, ready always 1 -> err_o=0, msg_count_o=1 after 9 cycles from reset release.
- Same message with last asserted on beat 5 -> err_o=1, err_code_o=e_err_last, registered one cycle after beat 5; FSM still returns to e_idle after the 8th beat.
- v_i=1 and ready=0 at cycle 10; data_i changes at cycle 11 -> e_err_hold raised at cycle 12.
- timeout_p=16, v_i held 1 with ready 0 for 20 cycles -> e_err_timeout once at the 16th stall cycle; ready then 1 -> message completes, msg_count_o increments.
- header_i changes on beat 3 of 4; size 7 with block_width 512 -> e_err_header on channel 0 and e_err_size on channel 1 in the same cycle, each recorded independently.
- reset_i asserted mid-message (beat 2 of 8), then a fresh 1-beat has_data=0 message -> no error, msg_count_o=1.
